// File: rtl/fpu_exec_ctrl_pkg.sv
// fpu_exec_ctrl_pkg: shared FPU opcodes, control states and canonical NaN
package fpu_exec_ctrl_pkg;

    localparam logic [3:0]  OP_ADD    = 4'd0;
    localparam logic [3:0]  OP_SUB    = 4'd1;
    localparam logic [3:0]  OP_MUL    = 4'd2;
    localparam logic [3:0]  OP_DIV    = 4'd3;
    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;
    localparam logic [2:0]  FLAG_EXC  = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Opcodes above DIV have no FALU path and complete as an invalid operation
    function automatic logic op_ok(input logic [3:0] op);
        return op <= OP_DIV;
    endfunction

endpackage

// File: rtl/fpu_exec_ctrl_flags.sv
// fpu_exec_ctrl_flags: sticky accrued exception flags {exc,ovf,unf}
module fpu_exec_ctrl_flags (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       hs,
    input  logic [2:0] flags,
    output logic [2:0] fflags
);

    // Clear first, then accrue the flags of a result that is actually handed off
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) fflags <= '0;
        else        fflags <= (clr ? 3'b000 : fflags) | (hs ? flags : 3'b000);

endmodule

// File: rtl/fpu_exec_ctrl.sv
// fpu_exec_ctrl: single-slot issue/settle/retire control around a multicycle FALU
module fpu_exec_ctrl
    import fpu_exec_ctrl_pkg::*;
#(
    parameter int LAT_ADDSUB = 2,
    parameter int LAT_MUL    = 3,
    parameter int LAT_DIV    = 6
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [3:0]  IN_OP,
    input  logic [31:0] IN_A,
    input  logic [31:0] IN_B,
    input  logic [4:0]  IN_RD,
    output logic [31:0] FALU_A,
    output logic [31:0] FALU_B,
    output logic [3:0]  FALU_OP,
    input  logic [31:0] FALU_RESULT,
    input  logic        FALU_EXC,
    input  logic        FALU_OVF,
    input  logic        FALU_UNF,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [31:0] OUT_RESULT,
    output logic [4:0]  OUT_RD,
    output logic [2:0]  OUT_FLAGS,
    output logic [2:0]  FFLAGS,
    input  logic        FFLAGS_CLR,
    input  logic        FLUSH
);

    localparam int MAX_LAT = (LAT_DIV > LAT_MUL) ? ((LAT_DIV > LAT_ADDSUB) ? LAT_DIV : LAT_ADDSUB)
                                                 : ((LAT_MUL > LAT_ADDSUB) ? LAT_MUL : LAT_ADDSUB);
    localparam int CW = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_load;
    logic            bad_op;
    logic            accept;
    logic            finish;

    // Invalid opcodes get a one-cycle slot so they retire one edge after acceptance
    assign cnt_load = !op_ok(IN_OP)    ? '0 :
                      IN_OP == OP_MUL  ? CW'(LAT_MUL - 1) :
                      IN_OP == OP_DIV  ? CW'(LAT_DIV - 1) :
                                         CW'(LAT_ADDSUB - 1);
    assign accept   = IN_READY && IN_VALID && !FLUSH;
    assign finish   = state == ST_EXEC && cnt == '0 && !FLUSH;

    // State register
    always_ff @(posedge CLK or negedge RESET_N)
        if (!RESET_N) state <= ST_IDLE;
        else          state <= state_nxt;

    // Next state: flush wins everywhere; DONE leaves only on handshake
    always_comb
        state_nxt = FLUSH                ? ST_IDLE :
                    state == ST_IDLE     ? (IN_VALID ? ST_EXEC : ST_IDLE) :
                    state == ST_EXEC     ? (cnt == '0 ? ST_DONE : ST_EXEC) :
                    OUT_READY            ? ST_IDLE : ST_DONE;

    // Handshake outputs decoded from state
    always_comb begin
        IN_READY  = state == ST_IDLE;
        OUT_VALID = state == ST_DONE;
    end

    // Operand/tag capture on accept, settle countdown, result capture on the final settle edge
    always_ff @(posedge CLK or negedge RESET_N)
        if (!RESET_N) begin
            FALU_A     <= '0;
            FALU_B     <= '0;
            FALU_OP    <= '0;
            OUT_RD     <= '0;
            OUT_RESULT <= '0;
            OUT_FLAGS  <= '0;
            bad_op     <= 1'b0;
            cnt        <= '0;
        end else begin
            if (accept) begin
                FALU_A <= IN_A;
                FALU_B <= IN_B;
                if (op_ok(IN_OP)) FALU_OP <= IN_OP;
                OUT_RD <= IN_RD;
                bad_op <= !op_ok(IN_OP);
                cnt    <= cnt_load;
            end else if (state == ST_EXEC && cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
            if (finish) begin
                OUT_RESULT <= bad_op ? CANON_NAN : FALU_RESULT;
                OUT_FLAGS  <= bad_op ? FLAG_EXC : {FALU_EXC, FALU_OVF, FALU_UNF};
            end
        end

    fpu_exec_ctrl_flags u_flags (
        .clk    (CLK),
        .rst_n  (RESET_N),
        .clr    (FFLAGS_CLR),
        .hs     (OUT_VALID && OUT_READY && !FLUSH),
        .flags  (OUT_FLAGS),
        .fflags (FFLAGS)
    );

endmodule

// File: doc/fpu_exec_ctrl.md
FPU_EXEC_CTRL -- requirements
Module: fpu_exec_ctrl

Interface
REQ-001 SHALL have parameter LAT_ADDSUB, default 2, meaning cycles the FALU add/sub path is given to settle (multicycle path, min 1).
REQ-002 SHALL have parameter LAT_MUL, default 3, meaning settle cycles for multiply (min 1).
REQ-003 SHALL have parameter LAT_DIV, default 6, meaning settle cycles for divide (min 1).
REQ-004 SHALL have ports: CLK  input  1  clock; RESET_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: IN_VALID  input  1  issue request; IN_READY  output  1  block can accept.
REQ-006 SHALL have ports: IN_OP  input  4  0 add, 1 sub, 2 mul, 3 div; IN_A, IN_B  input  32  IEEE-754 single operands; IN_RD  input  5  destination tag.
REQ-007 SHALL have ports: FALU_A, FALU_B  output  32  registered operands to FALU; FALU_OP  output  4  registered opcode to FALU.
REQ-008 SHALL have ports: FALU_RESULT  input  32; FALU_EXC, FALU_OVF, FALU_UNF  input  1 each  FALU status.
REQ-009 SHALL have ports: OUT_VALID  output  1; OUT_READY  input  1; OUT_RESULT  output  32; OUT_RD  output  5; OUT_FLAGS  output  3  {exc,ovf,unf} of this result.
REQ-010 SHALL have ports: FFLAGS  output  3  sticky accrued {exc,ovf,unf}; FFLAGS_CLR  input  1  clear sticky flags; FLUSH  input  1  discard in-flight op.

Function
REQ-011 SHALL implement states IDLE, EXEC, DONE; IN_READY = (state==IDLE); OUT_VALID = (state==DONE).
REQ-012 SHALL, in IDLE with IN_VALID=1 at a rising edge, register IN_A/IN_B/IN_OP onto FALU_A/FALU_B/FALU_OP, IN_RD into a tag register, load counter with latency-1 for the op, and enter EXEC.
REQ-013 SHALL hold FALU_A, FALU_B, FALU_OP stable from acceptance until the next acceptance.
REQ-014 SHALL, in EXEC, decrement the counter each cycle; at the edge where it is 0, capture FALU_RESULT into OUT_RESULT and {FALU_EXC,FALU_OVF,FALU_UNF} into OUT_FLAGS, and enter DONE.
REQ-015 SHALL therefore assert OUT_VALID exactly LAT_x rising edges after the accepting edge.
REQ-016 SHALL, for IN_OP > 3, skip EXEC: enter DONE on the accepting edge+1 with OUT_RESULT=0x7FC00000, OUT_FLAGS=3'b100, FALU_OP unchanged.
REQ-017 SHALL hold OUT_RESULT, OUT_RD, OUT_FLAGS stable while OUT_VALID=1 and OUT_READY=0.
REQ-018 SHALL, in DONE with OUT_READY=1, return to IDLE at that edge; no new op accepted on the same edge (one op in flight, single-slot).
REQ-019 SHALL OR OUT_FLAGS into FFLAGS only on the output handshake edge (OUT_VALID & OUT_READY).
REQ-020 SHALL, if FFLAGS_CLR and a handshake coincide, clear then OR: FFLAGS = OUT_FLAGS.
REQ-021 SHALL, on FLUSH=1 at an edge in EXEC or DONE, return to IDLE, drop the result, leave FFLAGS unchanged; FLUSH in IDLE has priority over IN_VALID (no accept).
REQ-022 SHALL treat FLUSH coincident with an output handshake as flush (no FFLAGS update).
REQ-023 SHALL use a counter width sufficient for max(LAT_*)-1; no wrap-around is reachable.

Reset
REQ-024 SHALL, on RESET_N=0 asynchronously, enter IDLE; FALU_A=FALU_B=0, FALU_OP=0, OUT_RESULT=0, OUT_RD=0, OUT_FLAGS=0, FFLAGS=0, counter=0.
REQ-025 SHALL, on reset mid-EXEC or mid-DONE, discard the op; OUT_VALID=0 and IN_READY=1 during and after reset.

Structure
REQ-026 SHALL take opcode constants (ADD=0, SUB=1, MUL=2, DIV=3), state encodings and the canonical NaN 0x7FC00000 from a shared fpu package.
REQ-027 SHALL be flat RTL; the FALU is instantiated by the parent, not inside this block.
REQ-028 SHALL be implementable in 120-400 lines.

Verification
REQ-029 SHALL test: add 0x3FC00000+0x40100000, OUT_READY=1 -> OUT_VALID 2 edges after accept, OUT_RESULT=0x40700000, OUT_FLAGS=0.
REQ-030 SHALL test: mul 0x40000000*0x40400000 with OUT_READY=0 for 4 cycles -> OUT_VALID at edge 3, result 0x40C00000 held stable, IN_READY=0 until handshake.
REQ-031 SHALL test: div 0x3F800000/0x00000000 -> OUT_VALID at edge 6, OUT_FLAGS[2]=1, FFLAGS=3'b100 after handshake; FFLAGS_CLR pulse -> FFLAGS=0.
REQ-032 SHALL test: IN_OP=4'd7 -> OUT_RESULT=0x7FC00000, OUT_FLAGS=3'b100 one edge after accept.
REQ-033 SHALL test: FLUSH at cycle 1 of a div -> IDLE next edge, no OUT_VALID, FFLAGS unchanged; next add completes normally.
REQ-034 SHALL test: RESET_N low mid-EXEC of mul -> all outputs at reset values asynchronously, IN_READY=1 after release.
